// File: rtl/pkt_rx_drain_chk.sv
// RX sink/checker behind the xge_mac packet interface: pops frames, checks framing,
// length and payload pattern, and keeps saturating good/bad/byte/framing counters.
module pkt_rx_drain_chk #(
  parameter int unsigned MAX_PKT_BYTES = 9600,
  parameter int unsigned MIN_PKT_BYTES = 1,
  parameter bit          CHK_PATTERN   = 1'b1,
  parameter int unsigned GAP_CYCLES    = 2,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25,
  input  logic             enable,
  input  logic             clr_cnt,
  input  logic             pkt_rx_avail,
  output logic             pkt_rx_ren,
  input  logic             pkt_rx_val,
  input  logic             pkt_rx_sop,
  input  logic             pkt_rx_eop,
  input  logic [2:0]       pkt_rx_mod,
  input  logic             pkt_rx_err,
  input  logic [63:0]      pkt_rx_data,
  output logic             pkt_done,
  output logic             pkt_done_ok,
  output logic [15:0]      last_len,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [CNT_W-1:0] frm_err_cnt
);

  localparam logic [16:0] LEN_SAT  = 17'(MAX_PKT_BYTES + 1);
  localparam logic [15:0] LEN_MAX  = 16'(MAX_PKT_BYTES);
  localparam logic [15:0] LEN_MIN  = 16'(MIN_PKT_BYTES);
  localparam logic [3:0]  GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, READ, GAP} state_t;

  state_t     state, state_nxt;
  logic [3:0] gap_cnt, gap_nxt;

  logic        in_frm;
  logic [15:0] len_q;
  logic [7:0]  exp_q;
  logic        bad_q;

  logic             start, drop, abort, close, good;
  logic [3:0]       nb;
  logic [7:0]       e_base;
  logic [16:0]      len_base, len_sum;
  logic [15:0]      len_new;
  logic             pat_bad_w, bad_new;
  logic [CNT_W-1:0] bad_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    case (state)
      IDLE: if (enable && pkt_rx_avail) state_nxt = READ;
      READ: if (pkt_rx_val && pkt_rx_eop) begin
        gap_nxt   = '0;
        state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
        else                     gap_nxt   = gap_cnt + 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      pkt_rx_ren <= 1'b0;
    end else begin
      state      <= state_nxt;
      gap_cnt    <= gap_nxt;
      pkt_rx_ren <= (state_nxt == READ);
    end
  end

  // Word-level datapath: an SOP word restarts length/pattern/bad tracking in place.
  always_comb begin
    start    = pkt_rx_val & pkt_rx_sop;
    drop     = pkt_rx_val & ~pkt_rx_sop & ~in_frm;
    abort    = start & in_frm;
    close    = pkt_rx_val & pkt_rx_eop & (in_frm | pkt_rx_sop);
    nb       = (pkt_rx_eop && pkt_rx_mod != 3'd0) ? {1'b0, pkt_rx_mod} : 4'd8;
    e_base   = pkt_rx_sop ? 8'd0 : exp_q;
    len_base = pkt_rx_sop ? 17'd0 : {1'b0, len_q};
    len_sum  = len_base + 17'(nb);
    len_new  = (len_sum > LEN_SAT) ? LEN_SAT[15:0] : len_sum[15:0];
    pat_bad_w = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (CHK_PATTERN && (4'(i) < nb) &&
          (pkt_rx_data[63-8*i -: 8] != (e_base + 8'(i))))
        pat_bad_w = 1'b1;
    end
    bad_new = (pkt_rx_sop ? 1'b0 : bad_q) | pat_bad_w;
    good    = ~pkt_rx_err & ~bad_new & (len_new >= LEN_MIN) & (len_new <= LEN_MAX);
    // An SOP+EOP word arriving mid-frame closes two frames at once.
    bad_inc = CNT_W'(abort) + CNT_W'(close & ~good);
  end

  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      in_frm <= 1'b0;
      len_q  <= '0;
      exp_q  <= '0;
      bad_q  <= 1'b0;
    end else if (pkt_rx_val && (in_frm || pkt_rx_sop)) begin
      in_frm <= ~pkt_rx_eop;
      len_q  <= len_new;
      exp_q  <= e_base + 8'd8;
      bad_q  <= bad_new;
    end
  end

  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      pkt_done    <= 1'b0;
      pkt_done_ok <= 1'b0;
      last_len    <= '0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      byte_cnt    <= '0;
      frm_err_cnt <= '0;
    end else begin
      pkt_done    <= close | abort;
      pkt_done_ok <= close & good;
      if (clr_cnt) begin
        last_len    <= '0;
        good_cnt    <= '0;
        bad_cnt     <= '0;
        byte_cnt    <= '0;
        frm_err_cnt <= '0;
      end else begin
        if (close)      last_len <= len_new;
        else if (abort) last_len <= len_q;
        if (close && good) begin
          good_cnt <= sat_add(good_cnt, CNT_W'(1));
          byte_cnt <= sat_add(byte_cnt, CNT_W'(len_new));
        end
        bad_cnt <= sat_add(bad_cnt, bad_inc);
        if (drop || abort) frm_err_cnt <= sat_add(frm_err_cnt, CNT_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_pkt_rx_drain_chk.sv
// Directed bench for pkt_rx_drain_chk: the bench plays the MAC RX FIFO and
// compares outputs against hand-computed values.
module tb_pkt_rx_drain_chk;

  logic        clk_156m25_tb = 1'b0;
  logic        reset_156m25  = 1'b1;
  logic        enable        = 1'b0;
  logic        clr_cnt       = 1'b0;
  logic        pkt_rx_avail  = 1'b0;
  logic        pkt_rx_ren;
  logic        pkt_rx_val    = 1'b0;
  logic        pkt_rx_sop    = 1'b0;
  logic        pkt_rx_eop    = 1'b0;
  logic [2:0]  pkt_rx_mod    = 3'd0;
  logic        pkt_rx_err    = 1'b0;
  logic [63:0] pkt_rx_data   = '0;
  logic        pkt_done;
  logic        pkt_done_ok;
  logic [15:0] last_len;
  logic [31:0] good_cnt, bad_cnt, byte_cnt, frm_err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pkt_rx_drain_chk #(
    .MAX_PKT_BYTES(9600),
    .MIN_PKT_BYTES(1),
    .CHK_PATTERN(1'b1),
    .GAP_CYCLES(2),
    .CNT_W(32)
  ) dut (
    .clk_156m25   (clk_156m25_tb),
    .reset_156m25 (reset_156m25),
    .enable       (enable),
    .clr_cnt      (clr_cnt),
    .pkt_rx_avail (pkt_rx_avail),
    .pkt_rx_ren   (pkt_rx_ren),
    .pkt_rx_val   (pkt_rx_val),
    .pkt_rx_sop   (pkt_rx_sop),
    .pkt_rx_eop   (pkt_rx_eop),
    .pkt_rx_mod   (pkt_rx_mod),
    .pkt_rx_err   (pkt_rx_err),
    .pkt_rx_data  (pkt_rx_data),
    .pkt_done     (pkt_done),
    .pkt_done_ok  (pkt_done_ok),
    .last_len     (last_len),
    .good_cnt     (good_cnt),
    .bad_cnt      (bad_cnt),
    .byte_cnt     (byte_cnt),
    .frm_err_cnt  (frm_err_cnt)
  );

  always #5 clk_156m25_tb = ~clk_156m25_tb;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_156m25_tb);
    #1;
  endtask

  function automatic logic [63:0] mk_word(input int w, input int nbytes, input int bad_idx);
    logic [63:0] d;
    logic [7:0]  b;
    int k;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      k = 8 * w + i;
      b = (k < nbytes) ? 8'(k) : 8'hEE;
      if (k == bad_idx) b = ~b;
      d[63-8*i -: 8] = b;
    end
    return d;
  endfunction

  // Sends a frame of nbytes; max_words > 0 truncates it (no EOP driven).
  task automatic send_frame(input int nbytes, input int bad_idx, input bit err, input int max_words);
    int words, nsend, n;
    words = (nbytes + 7) / 8;
    nsend = (max_words > 0 && max_words < words) ? max_words : words;
    pkt_rx_avail = 1'b1;
    n = 0;
    while (pkt_rx_ren !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check_eq("ren_wait", pkt_rx_ren, 1);
    pkt_rx_avail = 1'b0;
    for (int w = 0; w < nsend; w++) begin
      pkt_rx_val  = 1'b1;
      pkt_rx_sop  = (w == 0);
      pkt_rx_eop  = (max_words == 0) && (w == words - 1);
      pkt_rx_mod  = pkt_rx_eop ? 3'(nbytes % 8) : 3'd0;
      pkt_rx_err  = pkt_rx_eop ? err : 1'b0;
      pkt_rx_data = mk_word(w, nbytes, bad_idx);
      tick();
    end
    pkt_rx_val = 1'b0;
    pkt_rx_sop = 1'b0;
    pkt_rx_eop = 1'b0;
    pkt_rx_err = 1'b0;
  endtask

  task automatic clear_counters();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    check_eq("rst_ren", pkt_rx_ren, 0);
    check_eq("rst_done", pkt_done, 0);
    check_eq("rst_len", last_len, 0);
    check_eq("rst_good", good_cnt, 0);
    check_eq("rst_bad", bad_cnt, 0);
    check_eq("rst_byte", byte_cnt, 0);
    check_eq("rst_frm", frm_err_cnt, 0);
    reset_156m25 = 1'b0;

    // enable low: no pop even with a frame available
    pkt_rx_avail = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("dis_ren", pkt_rx_ren, 0);
    end
    pkt_rx_avail = 1'b0;
    enable = 1'b1;

    // 1: 64B pattern frame
    send_frame(64, -1, 1'b0, 0);
    check_eq("t1_done", pkt_done, 1);
    check_eq("t1_ok", pkt_done_ok, 1);
    check_eq("t1_len", last_len, 64);
    check_eq("t1_good", good_cnt, 1);
    check_eq("t1_byte", byte_cnt, 64);
    check_eq("t1_ren_off", pkt_rx_ren, 0);
    tick();
    check_eq("t1_pulse", pkt_done, 0);

    // 2: 61B then 1B frame
    clear_counters();
    check_eq("clr_good", good_cnt, 0);
    check_eq("clr_len", last_len, 0);
    send_frame(61, -1, 1'b0, 0);
    check_eq("t2a_ok", pkt_done_ok, 1);
    check_eq("t2a_len", last_len, 61);
    send_frame(1, -1, 1'b0, 0);
    check_eq("t2b_done", pkt_done, 1);
    check_eq("t2b_ok", pkt_done_ok, 1);
    check_eq("t2b_len", last_len, 1);
    check_eq("t2_good", good_cnt, 2);
    check_eq("t2_byte", byte_cnt, 62);

    // 3: byte 9 corrupted
    clear_counters();
    send_frame(64, 9, 1'b0, 0);
    check_eq("t3_done", pkt_done, 1);
    check_eq("t3_ok", pkt_done_ok, 0);
    check_eq("t3_bad", bad_cnt, 1);
    check_eq("t3_good", good_cnt, 0);
    check_eq("t3_byte", byte_cnt, 0);

    // 4: SOP after 3 words, then a full 16B frame
    clear_counters();
    send_frame(64, -1, 1'b0, 3);
    send_frame(16, -1, 1'b0, 0);
    check_eq("t4_ok", pkt_done_ok, 1);
    check_eq("t4_len", last_len, 16);
    check_eq("t4_frm", frm_err_cnt, 1);
    check_eq("t4_bad", bad_cnt, 1);
    check_eq("t4_good", good_cnt, 1);
    check_eq("t4_byte", byte_cnt, 16);

    // stray word outside a frame, and a MAC-flagged error frame
    clear_counters();
    pkt_rx_val  = 1'b1;
    pkt_rx_data = 64'h1234;
    tick();
    pkt_rx_val = 1'b0;
    check_eq("stray_frm", frm_err_cnt, 1);
    check_eq("stray_done", pkt_done, 0);
    send_frame(8, -1, 1'b1, 0);
    check_eq("err_ok", pkt_done_ok, 0);
    check_eq("err_len", last_len, 8);
    check_eq("err_bad", bad_cnt, 1);
    check_eq("err_good", good_cnt, 0);

    // 5: oversize frame, length saturates at MAX+1
    clear_counters();
    send_frame(9608, -1, 1'b0, 0);
    check_eq("t5_done", pkt_done, 1);
    check_eq("t5_ok", pkt_done_ok, 0);
    check_eq("t5_len", last_len, 9601);
    check_eq("t5_bad", bad_cnt, 1);
    check_eq("t5_byte", byte_cnt, 0);

    // 6: reset mid-frame, then a good frame
    send_frame(64, -1, 1'b0, 4);
    reset_156m25 = 1'b1;
    tick();
    tick();
    check_eq("t6_bad", bad_cnt, 0);
    check_eq("t6_len", last_len, 0);
    check_eq("t6_done", pkt_done, 0);
    check_eq("t6_ren", pkt_rx_ren, 0);
    reset_156m25 = 1'b0;
    tick();
    send_frame(64, -1, 1'b0, 0);
    check_eq("t6_ok", pkt_done_ok, 1);
    check_eq("t6_good", good_cnt, 1);
    check_eq("t6_byte", byte_cnt, 64);
    check_eq("t6_bad2", bad_cnt, 0);
    check_eq("t6_frm", frm_err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
